// File: rtl/ita_activation_stream_if.sv
// Valid/ready beat channel carrying N_LANES packed int8 lanes.
// The block uses one instance for its input stream and one for its output stream.
interface ita_activation_stream_if #(
    parameter int N_LANES = 16,
    parameter int WI      = 8
);
    logic                    valid;
    logic                    ready;
    logic [N_LANES*WI-1:0]   data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ita_activation_stream.sv
// Per-lane activation (identity / ReLU / i-GELU), requantisation and int8 saturation.
// The pipeline has three stages under one global stall, plus a saturated-lane counter.
module ita_activation_stream #(
    parameter int N_LANES              = 16,
    parameter int SAT_CNT_W            = 16,
    parameter int WI                   = 8,
    parameter int GELU_CONSTANTS_WIDTH = 16,
    parameter int EMS                  = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    ita_activation_stream_if.slave                 in_s,
    ita_activation_stream_if.master                out_s,
    input  logic [1:0]                             mode_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] one_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] b_i,
    input  logic signed [GELU_CONSTANTS_WIDTH-1:0] c_i,
    input  logic [EMS-1:0]                         eps_mult_i,
    input  logic [EMS-1:0]                         right_shift_i,
    input  logic signed [WI-1:0]                   add_i,
    input  logic                                   sat_clear_i,
    output logic [SAT_CNT_W-1:0]                   sat_count_o
);
    localparam int AW   = 64;
    localparam int PCW  = $clog2(N_LANES + 1);
    localparam int SUMW = ((SAT_CNT_W > PCW) ? SAT_CNT_W : PCW) + 1;
    localparam logic signed [AW-1:0] OUT_MAX = AW'(2**(WI-1) - 1);
    localparam logic signed [AW-1:0] OUT_MIN = AW'(-(2**(WI-1)));

    logic                  en;
    logic                  s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic [EMS-1:0]        s1_eps_reg, s1_shift_reg, s2_shift_reg;
    logic signed [WI-1:0]  s1_add_reg, s2_add_reg;
    logic signed [AW-1:0]  one_ext, b_ext, c_ext, neg_b, eps_ext, add_ext, rnd;
    logic [N_LANES-1:0]    sat_mask;

    // One enable for every stage: the pipe only moves when the output slot frees up.
    assign en          = out_s.ready || !s3_valid_reg;
    assign in_s.ready  = en;
    assign out_s.valid = s3_valid_reg;

    always_comb begin
        one_ext = AW'(one_i);
        b_ext   = AW'(b_i);
        c_ext   = AW'(c_i);
        neg_b   = -b_ext;
        eps_ext = AW'(s1_eps_reg);
        add_ext = AW'(s2_add_reg);
        rnd     = '0;
        if (s2_shift_reg != '0) begin
            rnd = AW'(1) << (s2_shift_reg - EMS'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
            s1_eps_reg   <= '0;
            s1_shift_reg <= '0;
            s2_shift_reg <= '0;
            s1_add_reg   <= '0;
            s2_add_reg   <= '0;
        end else if (en) begin
            s1_valid_reg <= in_s.valid;
            s2_valid_reg <= s1_valid_reg;
            s3_valid_reg <= s2_valid_reg;
            s1_eps_reg   <= eps_mult_i;
            s1_shift_reg <= right_shift_i;
            s1_add_reg   <= add_i;
            s2_shift_reg <= s1_shift_reg;
            s2_add_reg   <= s1_add_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic signed [WI-1:0] x_lane;
            logic signed [AW-1:0] x_ext, x_abs, q_abs, q_sq, q_l;
            logic signed [AW-1:0] act_next, act_reg, prod_next, prod_reg, r_val;
            logic [WI-1:0]        lane_out_next, lane_out_reg;
            logic                 lane_sat_next, lane_sat_reg;

            assign x_lane = in_s.data[gi*WI +: WI];

            always_comb begin
                x_ext = AW'(x_lane);
                x_abs = x_ext[AW-1] ? -x_ext : x_ext;
                q_abs = (x_abs < neg_b) ? x_abs : neg_b;
                q_sq  = (q_abs + b_ext) * (q_abs + b_ext) + c_ext;
                // Zero counts as positive, so only strictly negative inputs flip q_L.
                q_l   = x_ext[AW-1] ? -q_sq : q_sq;
                case (mode_i)
                    2'b01:   act_next = x_ext[AW-1] ? '0 : x_ext;
                    2'b10:   act_next = x_ext * (q_l + one_ext);
                    default: act_next = x_ext;
                endcase
            end

            always_comb begin
                prod_next     = act_reg * eps_ext;
                r_val         = ((prod_reg + rnd) >>> s2_shift_reg) + add_ext;
                lane_sat_next = 1'b0;
                lane_out_next = r_val[WI-1:0];
                if (r_val > OUT_MAX) begin
                    lane_out_next = OUT_MAX[WI-1:0];
                    lane_sat_next = 1'b1;
                end else if (r_val < OUT_MIN) begin
                    lane_out_next = OUT_MIN[WI-1:0];
                    lane_sat_next = 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    act_reg      <= '0;
                    prod_reg     <= '0;
                    lane_out_reg <= '0;
                    lane_sat_reg <= 1'b0;
                end else if (en) begin
                    act_reg      <= act_next;
                    prod_reg     <= prod_next;
                    lane_out_reg <= lane_out_next;
                    lane_sat_reg <= lane_sat_next;
                end
            end

            assign out_s.data[gi*WI +: WI] = lane_out_reg;
            assign sat_mask[gi]            = lane_sat_reg;
        end
    endgenerate

    logic [PCW-1:0]       sat_pop;
    logic [SUMW-1:0]      sat_sum;
    logic [SAT_CNT_W-1:0] sat_cnt_reg, sat_cnt_next;

    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < N_LANES; i++) begin
            sat_pop = sat_pop + PCW'(sat_mask[i]);
        end
        sat_sum      = SUMW'(sat_cnt_reg) + SUMW'(sat_pop);
        sat_cnt_next = sat_cnt_reg;
        if (sat_clear_i) begin
            sat_cnt_next = '0;
        end else if (s3_valid_reg && out_s.ready) begin
            // Stick at all-ones instead of wrapping.
            sat_cnt_next = (sat_sum > SUMW'({SAT_CNT_W{1'b1}})) ? '1 : sat_sum[SAT_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_reg <= '0;
        end else begin
            sat_cnt_reg <= sat_cnt_next;
        end
    end

    assign sat_count_o = sat_cnt_reg;
endmodule

// File: tb/tb_ita_activation_stream.sv
// Directed, table-driven bench for ita_activation_stream.
// Also runs hand-written sequences for stalls, counter clear/cap and mid-stream reset.
module tb_ita_activation_stream;
    localparam int NL = 16;
    localparam int W  = 8;
    localparam int NV = 9;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    ita_activation_stream_if #(.N_LANES(NL), .WI(W)) in_if ();
    ita_activation_stream_if #(.N_LANES(NL), .WI(W)) out_if ();

    logic [1:0]         mode_i;
    logic signed [15:0] one_i, b_i, c_i;
    logic [7:0]         eps_mult_i, right_shift_i;
    logic signed [7:0]  add_i;
    logic               sat_clear_i;
    logic [15:0]        sat_count_o;

    ita_activation_stream dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .in_s          (in_if),
        .out_s         (out_if),
        .mode_i        (mode_i),
        .one_i         (one_i),
        .b_i           (b_i),
        .c_i           (c_i),
        .eps_mult_i    (eps_mult_i),
        .right_shift_i (right_shift_i),
        .add_i         (add_i),
        .sat_clear_i   (sat_clear_i),
        .sat_count_o   (sat_count_o)
    );

    typedef struct packed {
        logic [1:0]        mode;
        logic [15:0]       one;
        logic [15:0]       b;
        logic [15:0]       c;
        logic [7:0]        eps;
        logic [7:0]        sh;
        logic [7:0]        add;
        logic [3:0][7:0]   x;
        logic [3:0][7:0]   y;
        logic [7:0]        sat;
    } vec_t;

    vec_t vecs [NV];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_sat = 0;

    function automatic vec_t mk(input logic [1:0] m, input int one, input int b, input int c,
                                input int eps, input int sh, input int add,
                                input int x0, input int x1, input int x2, input int x3,
                                input int y0, input int y1, input int y2, input int y3,
                                input int sat);
        vec_t v;
        v.mode = m;
        v.one  = 16'(one);
        v.b    = 16'(b);
        v.c    = 16'(c);
        v.eps  = 8'(eps);
        v.sh   = 8'(sh);
        v.add  = 8'(add);
        v.x[0] = 8'(x0); v.x[1] = 8'(x1); v.x[2] = 8'(x2); v.x[3] = 8'(x3);
        v.y[0] = 8'(y0); v.y[1] = 8'(y1); v.y[2] = 8'(y2); v.y[3] = 8'(y3);
        v.sat  = 8'(sat);
        return v;
    endfunction

    function automatic logic [NL*W-1:0] expand(input logic [3:0][7:0] v);
        logic [NL*W-1:0] r;
        for (int k = 0; k < NL; k++) begin
            r[k*W +: W] = v[k % 4];
        end
        return r;
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mode_i        = v.mode;
        one_i         = v.one;
        b_i           = v.b;
        c_i           = v.c;
        eps_mult_i    = v.eps;
        right_shift_i = v.sh;
        add_i         = v.add;
        in_if.data    = expand(v.x);
    endtask

    initial begin
        int   in_idx, out_idx, cyc, extra;
        logic stalled;
        logic [NL*W-1:0] held;

        // mode one b c eps sh add | x lanes | expected lanes | saturated lanes of 16
        vecs[0] = mk(2'b00,  0,   0,   0, 1, 0,   0,   -5,  -5,  -5,  -5,   -5,  -5,  -5,  -5,  0);
        vecs[1] = mk(2'b01,  0,   0,   0, 1, 0,   3,   -5,   7,  -5,   7,    3,  10,   3,  10,  0);
        vecs[2] = mk(2'b10, 50, -20, 100, 1, 4,   0,    5,  -5,   0,  30,  117,  86,   0, 127,  4);
        vecs[3] = mk(2'b00,  0,   0,   0, 3, 1,   0,  100, 100, 100, 100,  127, 127, 127, 127, 16);
        vecs[4] = mk(2'b11,  0,   0,   0, 1, 0,   0, -128, 127,   1,  -1, -128, 127,   1,  -1,  0);
        vecs[5] = mk(2'b00,  0,   0,   0, 3, 1,   0, -100,  10,-100,  10, -128,  15,-128,  15,  8);
        vecs[6] = mk(2'b01,  0,   0,   0, 2, 2, -10,    0,   5,  -7, 127,  -10,  -7, -10,  54,  0);
        vecs[7] = mk(2'b10, 50, -20, 100, 1, 4,   0,  -30,  20,  -1,   1,   94, 127,  26,  32,  4);
        vecs[8] = mk(2'b00,  0,   0,   0, 1, 0, -20, -120,   0,   0,   0, -128, -20, -20, -20,  4);

        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;
        sat_clear_i  = 1'b0;
        drive(vecs[0]);

        // Reset state.
        #1 rst_ni = 1'b0;
        #2;
        check("rst_valid_o", out_if.valid, 0);
        check("rst_data_o", out_if.data, 0);
        check("rst_sat_count", sat_count_o, 0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1 check("rst_ready_o", in_if.ready, 1);

        // Single beats through an idle pipe: exact latency, data and counter.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk_i); #1;
            drive(vecs[i]);
            in_if.valid = 1'b1;
            @(posedge clk_i); #1;
            in_if.valid = 1'b0;
            @(posedge clk_i); #1;
            check("latency_early", out_if.valid, 0);
            @(posedge clk_i); #1;
            check("latency_valid", out_if.valid, 1);
            check("vec_data", out_if.data, expand(vecs[i].y));
            $display("vec %0d mode %0d in %h out %h", i, vecs[i].mode, expand(vecs[i].x), out_if.data);
            @(posedge clk_i); #1;
            exp_sat = sat_add(exp_sat, int'(vecs[i].sat));
            check("vec_sat_count", sat_count_o, exp_sat);
        end

        // Clear coinciding with a saturating handshake wins.
        drive(vecs[3]);
        in_if.valid = 1'b1;
        @(posedge clk_i); #1;
        in_if.valid = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("clr_valid", out_if.valid, 1);
        sat_clear_i = 1'b1;
        @(posedge clk_i); #1;
        sat_clear_i = 1'b0;
        exp_sat = 0;
        check("clr_sat_count", sat_count_o, 0);
        $display("clear with saturating beat, sat_count %0d", sat_count_o);

        // Stream with ready 1,0,0,1 and random bubbles; expectations from the table.
        in_idx = 0; out_idx = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (out_idx < 10 && cyc < 400) begin
            @(posedge clk_i); #1;
            out_if.ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (in_idx < 10 && $urandom_range(0, 3) != 0) begin
                drive(vecs[in_idx % NV]);
                in_if.valid = 1'b1;
            end else begin
                in_if.valid = 1'b0;
            end
            #1;
            if (stalled) begin
                check("stall_valid", out_if.valid, 1);
                check("stall_data", out_if.data, held);
            end
            if (out_if.valid && out_if.ready) begin
                check("stream_data", out_if.data, expand(vecs[out_idx % NV].y));
                $display("stream beat %0d out %h", out_idx, out_if.data);
                exp_sat = sat_add(exp_sat, int'(vecs[out_idx % NV].sat));
                out_idx++;
            end
            stalled = out_if.valid && !out_if.ready;
            held    = out_if.data;
            if (in_if.valid && in_if.ready) in_idx++;
            cyc++;
        end
        check("stream_count", 128'(out_idx), 10);
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(posedge clk_i); #1;
            if (out_if.valid) extra++;
        end
        check("stream_no_dup", 128'(extra), 0);
        check("stream_sat_count", sat_count_o, exp_sat);

        // Saturating counter caps at all-ones.
        drive(vecs[3]);
        in_if.valid = 1'b1;
        repeat (4100) @(posedge clk_i);
        #1 in_if.valid = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        check("sat_cap", sat_count_o, 16'hFFFF);
        $display("counter after 4100 saturating beats %0d", sat_count_o);

        // Reset with three beats in flight.
        out_if.ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk_i); #1;
            drive(vecs[j + 2]);
            in_if.valid = 1'b1;
        end
        @(posedge clk_i); #1;
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        check("inflight_valid", out_if.valid, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst_valid_o", out_if.valid, 0);
        check("midrst_data_o", out_if.data, 0);
        check("midrst_sat_count", sat_count_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        out_if.ready = 1'b1;
        #1 check("midrst_ready_o", in_if.ready, 1);
        extra = 0;
        repeat (8) begin
            @(posedge clk_i); #1;
            if (out_if.valid) extra++;
        end
        check("midrst_no_output", 128'(extra), 0);
        $display("mid-stream reset, outputs after release %0d", extra);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
